alu_issue_stage: RTL

Registered issue stage directly upstream of the 32-bit ALU. Decodes a MIPS instruction word plus its register-file operands into the ALU's `A`, `B` and `Aluop`, and holds them under a valid/ready handshake. The handshake lets the ALU's multi-cycle ops (mod) back-pressure decode. A 2-entry buffer (output register plus skid register) keeps `in_ready` a registered signal.

---
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the 32-bit ALU: MIPS decode into A/B/Aluop/dest plus a 2-entry skid buffer.
// Optional writeback operand bypass at accept time is enabled with `define ALU_ISSUE_BYPASS_EN.
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              wb_valid,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        Aluop,
  output logic [4:0]        dest,
  output logic              illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a held entry stays stable until it transfers.

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [4:0]        dest;
    logic              illegal;
  } entry_t;

  entry_t dec, out_q, sk_q;
  logic   sk_valid;
  logic   accept, issue;
  logic [DATA_W-1:0] rs_op, rt_op;

  wire [5:0]  opcode = instr[31:26];
  wire [4:0]  rs_idx = instr[25:21];
  wire [4:0]  rt_idx = instr[20:16];
  wire [4:0]  rd_idx = instr[15:11];
  wire [5:0]  funct  = instr[5:0];
  wire [15:0] imm    = instr[15:0];

  wire [DATA_W-1:0] imm_sx = {{(DATA_W-16){imm[15]}}, imm};
  wire [DATA_W-1:0] imm_zx = {{(DATA_W-16){1'b0}}, imm};

`ifdef ALU_ISSUE_BYPASS_EN
  always_comb begin
    rs_op = rs_data;
    rt_op = rt_data;
    if (wb_valid && wb_dest != 5'd0 && wb_dest == rs_idx) rs_op = wb_data;
    if (wb_valid && wb_dest != 5'd0 && wb_dest == rt_idx) rt_op = wb_data;
  end
`else
  assign rs_op = rs_data;
  assign rt_op = rt_data;
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_dest, wb_data};
`endif

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    if (opcode == 6'h00) begin
      dec.a = rs_op; dec.b = rt_op; dec.dest = rd_idx; dec.illegal = 1'b0;
      case (funct)
        6'h24:        dec.op = 3'b000;
        6'h25:        dec.op = 3'b001;
        6'h26:        dec.op = 3'b010;
        6'h27:        dec.op = 3'b011;
        6'h20, 6'h21: dec.op = 3'b101;
        6'h22, 6'h23: dec.op = 3'b110;
        6'h2A:        dec.op = 3'b100;
        6'h1B:        dec.op = 3'b111;
        default:      dec = '{default: '0, illegal: 1'b1};
      endcase
    end else begin
      dec.a = rs_op; dec.dest = rt_idx; dec.illegal = 1'b0;
      case (opcode)
        6'h08:   begin dec.op = 3'b101; dec.b = imm_sx; end
        6'h0A:   begin dec.op = 3'b100; dec.b = imm_sx; end
        6'h0C:   begin dec.op = 3'b000; dec.b = imm_zx; end
        6'h0D:   begin dec.op = 3'b001; dec.b = imm_zx; end
        6'h0E:   begin dec.op = 3'b010; dec.b = imm_zx; end
        default: dec = '{default: '0, illegal: 1'b1};
      endcase
    end
  end

  assign in_ready = ~sk_valid;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready;

  // Skid full implies no accept, so the skid entry and a new entry never compete for the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
      out_q     <= '0;
      sk_q      <= '0;
    end else if (issue) begin
      if (sk_valid) begin
        out_q    <= sk_q;
        sk_valid <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end
    end else if (accept) begin
      sk_q     <= dec;
      sk_valid <= 1'b1;
    end
  end

  assign A       = out_q.a;
  assign B       = out_q.b;
  assign Aluop   = out_q.op;
  assign dest    = out_q.dest;
  assign illegal = out_q.illegal;

endmodule
